// File: rtl/fix_ascii_streamer.sv
// fix_ascii_streamer
// Output stage of the float-to-fixed display path. Captures a sign bit and two
// 4-character ASCII words (integer part, fraction part) and streams them as one
// text line over a valid/ready byte interface:
//   sign, integer digits, '.', fraction digits, CR, LF
// With SUPPRESS_LZ=1 leading '0' integer digits are dropped, but the last
// integer digit is always sent.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   i_start       one-cycle line request, honoured only while o_busy=0
//   i_sign        1 -> '-', 0 -> '+'
//   i_int_ascii   integer digits, MSB byte = most significant digit
//   i_frac_ascii  fraction digits, MSB byte = first digit after the point
//   o_data        current byte (registered)
//   o_valid       o_data holds a byte to transfer (registered)
//   i_ready       downstream accepts the byte at this edge
//   o_busy        a line is captured and not yet fully sent
//   o_done        one-cycle pulse in the cycle after the LF byte transfers
module fix_ascii_streamer #(
  parameter bit SUPPRESS_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_sign,
  input  logic [31:0] i_int_ascii,
  input  logic [31:0] i_frac_ascii,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_INT,
    S_DOT,
    S_FRAC,
    S_CR,
    S_LF
  } state_t;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic        sign_q, sign_n;
  logic [31:0] int_q, int_n;
  logic [31:0] frac_q, frac_n;
  logic [7:0]  data_n;
  logic        valid_n;
  logic        done_n;
  logic [1:0]  start_idx;
  logic        xfer;

  // Byte i of a 4-character word, i=0 being the most significant byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign xfer   = o_valid & i_ready;
  assign o_busy = (state != S_IDLE);

  // First integer digit to send, decided from the live input at capture time.
  // Any byte other than '0' ends suppression; digit 3 is never skipped.
  always_comb begin
    start_idx = 2'd0;
    if (SUPPRESS_LZ) begin
      if (i_int_ascii[31:24] != CH_ZERO)      start_idx = 2'd0;
      else if (i_int_ascii[23:16] != CH_ZERO) start_idx = 2'd1;
      else if (i_int_ascii[15:8] != CH_ZERO)  start_idx = 2'd2;
      else                                    start_idx = 2'd3;
    end
  end

  // Next-state logic. The outgoing byte is derived from the next state and
  // index so o_data/o_valid can be registered without a bubble: when no
  // transfer happens everything holds and o_data stays stable.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sign_n  = sign_q;
    int_n   = int_q;
    frac_n  = frac_q;
    done_n  = 1'b0;
    data_n  = o_data;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          sign_n  = i_sign;
          int_n   = i_int_ascii;
          frac_n  = i_frac_ascii;
          idx_n   = start_idx;
          state_n = S_SIGN;
        end
      end
      S_SIGN: begin
        if (xfer) state_n = S_INT;
      end
      S_INT: begin
        if (xfer) begin
          if (idx == 2'd3) begin
            state_n = S_DOT;
            idx_n   = 2'd0;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      S_DOT: begin
        if (xfer) state_n = S_FRAC;
      end
      S_FRAC: begin
        if (xfer) begin
          if (idx == 2'd3) state_n = S_CR;
          else             idx_n   = idx + 2'd1;
        end
      end
      S_CR: begin
        if (xfer) state_n = S_LF;
      end
      S_LF: begin
        if (xfer) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    case (state_n)
      S_SIGN:  data_n = sign_n ? CH_MINUS : CH_PLUS;
      S_INT:   data_n = pick_byte(int_n, idx_n);
      S_DOT:   data_n = CH_DOT;
      S_FRAC:  data_n = pick_byte(frac_n, idx_n);
      S_CR:    data_n = CH_CR;
      S_LF:    data_n = CH_LF;
      default: data_n = o_data;
    endcase

    valid_n = (state_n != S_IDLE);
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      sign_q  <= 1'b0;
      int_q   <= 32'h0;
      frac_q  <= 32'h0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      sign_q  <= sign_n;
      int_q   <= int_n;
      frac_q  <= frac_n;
      o_data  <= data_n;
      o_valid <= valid_n;
      o_done  <= done_n;
    end
  end

endmodule

// File: doc/fix_ascii_streamer.md
# fix_ascii_streamer

Output stage of the float-to-fixed display path. Captures the sign, the 4-digit ASCII integer word and the 4-digit ASCII fraction word produced by the integer/fraction decoders. Emits them as one text line, a byte at a time, over a valid/ready byte stream into the UART transmitter. The line format is sign, integer digits, '.', fraction digits, CR, LF, with optional leading-zero suppression on the integer part.

## Interface
- SUPPRESS_LZ, 1, when 1 the block skips leading ASCII '0' (0x30) integer digits, always keeping the last integer digit; when 0 it sends all 4 integer digits.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  one-cycle request to send a line; accepted only when o_busy=0.
- i_sign  input  1  1 sends '-' (0x2D), 0 sends '+' (0x2B).
- i_int_ascii  input  32  integer digits, MSB byte = most significant digit.
- i_frac_ascii  input  32  fraction digits, MSB byte = first digit after the point (e.g. 0x30363235 = "0625").
- o_data  output  8  current byte.
- o_valid  output  1  o_data holds a byte to transfer.
- i_ready  input  1  downstream accepts the byte at this edge.
- o_busy  output  1  a line is captured and not yet fully sent.
- o_done  output  1  one-cycle pulse in the cycle after the LF byte transfers.

## Operation
- Reset values: o_data=0x00, o_valid=0, o_busy=0, o_done=0, state IDLE, capture registers 0.
- Transfer occurs at a rising edge where o_valid=1 and i_ready=1.
- States and transitions:
  - IDLE: on i_start, register i_sign, i_int_ascii and i_frac_ascii, then go to SIGN.
  - SIGN → INT → DOT → FRAC → CR → LF → IDLE. Each state advances only on a transfer.
- INT start index: 0 when SUPPRESS_LZ=0. Otherwise it is the first index k in 0..2 whose digit byte is not 0x30, or 3 if bytes 0..2 are all 0x30.
  - The start index is computed at capture time.
  - INT sends digits k..3, then moves to DOT.
- FRAC sends all 4 bytes, MSB first.
- Fixed bytes: DOT=0x2E, CR=0x0D, LF=0x0A.
- Frame length: 12 bytes unsuppressed; 9..12 bytes with suppression.
- Input bytes are not range-checked; non-digit values pass through verbatim. A non-0x30 byte stops suppression.
- o_data and o_valid are registered. While o_valid=1 and i_ready=0, o_data stays stable and the state holds.
- o_valid stays 1 continuously from the SIGN byte through the LF byte. The stream has no internal bubbles.
- i_start while o_busy=1 is ignored. Captured values are unaffected by input changes during a frame.
- i_start in the o_done cycle is accepted, since the block is in IDLE then.

## Timing
- i_start sampled at edge N in IDLE:
  - o_busy=1 and o_valid=1 with o_data=sign from after edge N.
  - Start-to-first-byte latency is 1 cycle.
- With i_ready held 1, a transfer happens every cycle. An L-byte frame occupies cycles N+1..N+L.
- After the LF transfer edge: o_valid=0, o_busy=0 and o_done=1 for exactly one cycle.
- Minimum gap between lines: i_start at the o_done cycle gives the next sign byte one cycle later. That is 1 idle cycle between LF and the next sign.
- rst asserted mid-frame: all outputs go to their reset values immediately (asynchronous), with no o_done. The partial line is abandoned.
- After rst deasserts, the block is IDLE and the first i_start is accepted normally.

## Test plan
- SUPPRESS_LZ=1, i_sign=1, int 0x30303132, frac 0x30363235, i_ready=1:
  - Bytes 2D 31 32 2E 30 36 32 35 0D 0A on consecutive cycles.
  - o_done one cycle after 0A.
- SUPPRESS_LZ=1, i_sign=0, int 0x30303030, frac 0x30303030:
  - Bytes 2B 30 2E 30 30 30 30 0D 0A (single integer zero kept).
- SUPPRESS_LZ=0, int 0x30303039, frac 0x39333735:
  - 12 bytes 2B 30 30 30 39 2E 39 33 37 35 0D 0A.
- Backpressure: i_ready toggles 1,0,0,1,... randomly during the line.
  - o_data stays stable while not ready; byte sequence unchanged.
  - o_valid never drops mid-line.
- Second i_start mid-frame with different inputs: ignored; the first line completes unchanged.
  - A new i_start in the o_done cycle starts the next line one cycle later.
- rst pulsed after the third transfer: o_valid, o_busy, o_data and o_done read 0 before the next edge.
  - A following i_start produces a complete, correct line.
